aldffe_load_scheduler: RTL and testbench
========================================

# aldffe_load_scheduler

Two-requester scheduler that shares one enable/async-load flip-flop bank (D/EN synchronous path, AD/aload asynchronous-load path) between clients. It grants one request at a time round-robin and drives either a one-cycle enable write or a setup/pulse/hold async-load sequence. It acknowledges the requester when the sequence completes. It sits directly in front of the register bank and is its sole source of D, EN, AD and aload.

## Interface
Parameters:
- WIDTH, 2, data width of the controlled register bank
- SETUP_CYC, 1, cycles AD is stable before aload rises (1..255)
- PULSE_CYC, 1, cycles aload is held high (1..255)
- HOLD_CYC, 1, cycles AD is held after aload falls (1..255)

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  request from client 0 / 1, held until matching ack
- mode0 / mode1  in  1  0 = enable write (D/EN), 1 = async load (AD/aload)
- data0 / data1  in  WIDTH  value to write
- ack0 / ack1  out  1  one-cycle completion pulse
- d  out  WIDTH  register D input
- en  out  1  register enable
- ad  out  WIDTH  register async-load data
- aload  out  1  register async-load strobe
- busy  out  1  high whenever state != IDLE

## Operation
- All outputs are registered. Reset: state IDLE; d, en, ad, aload, ack0, ack1, busy = 0; priority pointer = client 0.
- States: IDLE, WRITE, SETUP, PULSE, HOLD, ACK.
- IDLE, arbitration:
  - With no request, the block stays in IDLE.
  - With exactly one request, that client is granted regardless of the pointer.
  - With both requesting, the pointer's client is granted.
  - On every grant the pointer moves to the other client.
- At grant, mode, data and the client index are latched. Later changes on the request inputs are ignored until ACK.
- Dropping req before ack is a protocol violation. The transaction still completes using the latched values, and the ack is still issued.
- IDLE->WRITE (mode 0): for exactly one cycle, en=1 and d=data. Then ->ACK.
- IDLE->SETUP (mode 1):
  - SETUP: ad=data, aload=0, for SETUP_CYC cycles, then ->PULSE.
  - PULSE: aload=1, ad held, for PULSE_CYC cycles, then ->HOLD.
  - HOLD: aload=0, ad held, for HOLD_CYC cycles, then ->ACK.
- ad retains its last value outside async transactions. d retains its last value; only en gates it.
- ACK: ack of the latched client =1 for one cycle, then ->IDLE. en and aload are 0.
- IDLE is always visited for at least one cycle between transactions. A request still held in the ACK cycle is not re-granted, because the requester sees ack and must drop req.
- Cycle counter is 8 bits. It loads (param-1) on state entry and exits on 0.
- Reset mid-transaction:
  - On the next edge, aload and en return to 0 and no ack is issued.
  - The client must still hold req and is re-arbitrated from the reset pointer.

## Timing
- Grant decision at edge T (IDLE samples req).
- Mode 0: en=1 during cycle T+1; ack during T+2; busy in T+1..T+2; next grant possible at edge T+3.
- Mode 1:
  - aload rises at T+1+SETUP_CYC and is high PULSE_CYC cycles.
  - ack during T+1+SETUP_CYC+PULSE_CYC+HOLD_CYC.
  - With defaults: ad valid from T+1, aload high in T+2, ack in T+4.
- en and aload are never high in the same cycle. ack0 and ack1 are never high together.

## Test plan
- Reset: assert rst 2 cycles during a PULSE phase -> aload=0, busy=0 and no ack within one edge; all outputs 0.
- Single mode-0 request, client 0, data0=2'b10 -> en=1 with d=2'b10 for exactly one cycle at T+1; ack0 at T+2; ack1 stays 0.
- Single mode-1 request, client 1, data1=2'b11, SETUP/PULSE/HOLD=2/3/1:
  - ad=2'b11 from T+1;
  - aload high T+3..T+5;
  - ack1 at T+7;
  - ad unchanged through T+7.
- Both clients request continuously (re-asserting after each ack) with mode0=0, mode1=1 -> grants alternate 0,1,0,1 from reset; each ack is one cycle; en/aload never overlap.
- Client 0 changes data0 from 2'b01 to 2'b10 mid-SETUP -> ad stays 2'b01 through HOLD; ack0 issued.
- Client drops req one cycle after grant in mode 1 -> sequence completes with latched data; ack still pulses; back to IDLE, busy=0.

Source files
------------

// File: rtl/aldffe_load_scheduler.sv
// Two-client round-robin scheduler driving one enable/async-load
// register bank: single-cycle EN writes or AD/aload setup/pulse/hold.
//
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   req0/req1       : client requests, held until the matching ack
//   mode0/mode1     : 0 = enable write (d/en), 1 = async load (ad/aload)
//   data0/data1     : value to write for each client
//   ack0/ack1       : one-cycle completion pulse to the granted client
//   d, en           : synchronous data path to the register bank
//   ad, aload       : asynchronous-load data and strobe
//   busy            : high whenever the scheduler is not idle
module aldffe_load_scheduler #(
    parameter int WIDTH     = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             mode0,
    input  logic             mode1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             ack0,
    output logic             ack1,
    output logic [WIDTH-1:0] d,
    output logic             en,
    output logic [WIDTH-1:0] ad,
    output logic             aload,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        SETUP,
        PULSE,
        HOLD,
        ACK
    } state_t;

    // Phase counters load (length - 1) so a phase ends when the count is 0.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] PULSE_LD = 8'(PULSE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ptr_q, ptr_d;
    logic              cli_q, cli_d;
    logic [WIDTH-1:0]  d_q, d_d;
    logic              en_q, en_d;
    logic [WIDTH-1:0]  ad_q, ad_d;
    logic              aload_q, aload_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;

    // Arbitration: a lone requester wins outright; on contention the
    // pointer decides.
    logic              any_req;
    logic              gnt1;
    logic              gnt_mode;
    logic [WIDTH-1:0]  gnt_data;

    assign any_req  = req0 | req1;
    assign gnt1     = req1 & (~req0 | ptr_q);
    assign gnt_mode = gnt1 ? mode1 : mode0;
    assign gnt_data = gnt1 ? data1 : data0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        cli_d   = cli_q;
        d_d     = d_q;
        en_d    = 1'b0;
        ad_d    = ad_q;
        aload_d = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    cli_d = gnt1;
                    ptr_d = ~gnt1;
                    if (gnt_mode) begin
                        state_d = SETUP;
                        ad_d    = gnt_data;
                        cnt_d   = SETUP_LD;
                    end else begin
                        state_d = WRITE;
                        d_d     = gnt_data;
                        en_d    = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = ACK;
                ack0_d  = ~cli_q;
                ack1_d  = cli_q;
            end
            SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = PULSE;
                    aload_d = 1'b1;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            PULSE: begin
                if (cnt_q == 8'd0) begin
                    state_d = HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    aload_d = 1'b1;
                    cnt_d   = cnt_q - 8'd1;
                end
            end
            HOLD: begin
                if (cnt_q == 8'd0) begin
                    state_d = ACK;
                    ack0_d  = ~cli_q;
                    ack1_d  = cli_q;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACK: begin
                // Always return through IDLE so a held request is
                // not granted again in the ack cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            ptr_q   <= 1'b0;
            cli_q   <= 1'b0;
            d_q     <= '0;
            en_q    <= 1'b0;
            ad_q    <= '0;
            aload_q <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            cli_q   <= cli_d;
            d_q     <= d_d;
            en_q    <= en_d;
            ad_q    <= ad_d;
            aload_q <= aload_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
        end
    end

    assign d     = d_q;
    assign en    = en_q;
    assign ad    = ad_q;
    assign aload = aload_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_aldffe_load_scheduler.sv
// Directed bench for aldffe_load_scheduler with SETUP/PULSE/HOLD = 2/3/1.
// Outputs are sampled 1 time unit after each rising edge.
module tb_aldffe_load_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, mode0, mode1;
    logic [1:0] data0, data1;
    logic       ack0, ack1, en, aload, busy;
    logic [1:0] d, ad;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    aldffe_load_scheduler #(
        .WIDTH(2),
        .SETUP_CYC(2),
        .PULSE_CYC(3),
        .HOLD_CYC(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req0(req0),
        .req1(req1),
        .mode0(mode0),
        .mode1(mode1),
        .data0(data0),
        .data1(data1),
        .ack0(ack0),
        .ack1(ack1),
        .d(d),
        .en(en),
        .ad(ad),
        .aload(aload),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_outs"}, {ack0, ack1, en, aload, busy, d, ad}, 0);
    endtask

    int acks[$];
    logic prev_ack;

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0; mode0 = 0; mode1 = 0;
        data0 = 0; data1 = 0;
        tick();
        tick();
        chk_zero("reset");
        rst = 1'b0;
        tick();
        chk_zero("idle");

        // Mode 0, client 0, data 2'b10.
        req0 = 1; mode0 = 0; data0 = 2'b10;
        tick();
        chk("w_en1", en, 1);
        chk("w_d", d, 2'b10);
        chk("w_busy1", busy, 1);
        chk("w_ack_early", {ack0, ack1}, 0);
        tick();
        chk("w_en2", en, 0);
        chk("w_ack", {ack0, ack1}, 2'b10);
        chk("w_busy2", busy, 1);
        req0 = 0;
        tick();
        chk("w_ack_end", {ack0, ack1}, 0);
        chk("w_busy3", busy, 0);
        chk("w_d_keep", d, 2'b10);

        // Mode 1, client 1, data 2'b11.
        req1 = 1; mode1 = 1; data1 = 2'b11;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk($sformatf("a_ad%0d", k), ad, 2'b11);
            chk($sformatf("a_aload%0d", k), aload,
                (k >= 3 && k <= 5) ? 1 : 0);
            chk($sformatf("a_ack%0d", k), {ack0, ack1},
                (k == 7) ? 2'b01 : 2'b00);
            chk($sformatf("a_en%0d", k), en, 0);
            chk($sformatf("a_busy%0d", k), busy, 1);
        end
        req1 = 0;
        tick();
        chk("a_idle", busy, 0);

        // Data changes mid-SETUP; latched value must persist.
        req0 = 1; mode0 = 1; data0 = 2'b01;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) data0 = 2'b10;
            chk($sformatf("c_ad%0d", k), ad, 2'b01);
            chk($sformatf("c_ack%0d", k), {ack0, ack1},
                (k == 7) ? 2'b10 : 2'b00);
        end
        req0 = 0;
        tick();
        chk("c_idle", busy, 0);

        // Request dropped one cycle after grant.
        req1 = 1; mode1 = 1; data1 = 2'b10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 1) req1 = 0;
            chk($sformatf("p_ad%0d", k), ad, 2'b10);
            chk($sformatf("p_aload%0d", k), aload,
                (k >= 3 && k <= 5) ? 1 : 0);
            chk($sformatf("p_ack%0d", k), {ack0, ack1},
                (k == 7) ? 2'b01 : 2'b00);
        end
        tick();
        chk("p_idle", busy, 0);
        chk("p_noack", {ack0, ack1}, 0);

        // Reset during PULSE.
        req0 = 1; mode0 = 1; data0 = 2'b11;
        tick();
        tick();
        tick();
        chk("r_pulse", aload, 1);
        rst = 1;
        tick();
        chk_zero("r_rst1");
        tick();
        chk_zero("r_rst2");
        rst = 0;
        tick();
        chk("r_regrant", busy, 1);
        chk("r_ad", ad, 2'b11);
        for (int k = 2; k <= 7; k++) begin
            tick();
            chk($sformatf("r_ack%0d", k), {ack0, ack1},
                (k == 7) ? 2'b10 : 2'b00);
        end
        req0 = 0;
        tick();
        chk("r_idle", busy, 0);

        // Round robin from reset: client 0 mode 0, client 1 mode 1.
        rst = 1;
        tick();
        rst = 0;
        mode0 = 0; mode1 = 1; data0 = 2'b01; data1 = 2'b10;
        req0 = 1; req1 = 1;
        prev_ack = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (en & aload) chk("rr_overlap", {en, aload}, 0);
            if (ack0 & ack1) chk("rr_ack_onehot", {ack0, ack1}, 2'b01);
            if (prev_ack & (ack0 | ack1))
                chk("rr_ack_width", 2, 1);
            if (ack0) acks.push_back(0);
            if (ack1) acks.push_back(1);
            prev_ack = ack0 | ack1;
            req0 = ~ack0;
            req1 = ~ack1;
        end
        chk("rr_count", (acks.size() >= 4) ? 1 : 0, 1);
        if (acks.size() >= 4) begin
            chk("rr_g0", acks[0], 0);
            chk("rr_g1", acks[1], 1);
            chk("rr_g2", acks[2], 0);
            chk("rr_g3", acks[3], 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
